// File: rtl/hazard_ctrl.sv
// hazard_ctrl: pipeline sequencer for the 3-stage core (IF/ID -> EX -> MEM/WB).
// Tracks EX/WB destinations, produces registered operand-forward selects,
// inserts load-use bubbles, flushes ID on redirect and freezes on dmem waits.
// Optional perf counters: define HAZARD_CTRL_PERF_EN.
module hazard_ctrl #(
  parameter int unsigned MEM_TIMEOUT = 255,
  parameter int unsigned CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             id_valid,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             id_rs1_used,
  input  logic             id_rs2_used,
  input  logic [4:0]       id_rd,
  input  logic             id_rd_we,
  input  logic             id_is_load,
  input  logic             ex_redirect,
  input  logic             dmem_req,
  input  logic             dmem_ready,
  output logic             stall_if,
  output logic             stall_id,
  output logic             stall_ex,
  output logic             bubble_ex,
  output logic             flush_id,
  output logic [1:0]       fwda,
  output logic [1:0]       fwdb,
  output logic             mem_err
`ifdef HAZARD_CTRL_PERF_EN
  ,
  output logic [CNT_W-1:0] perf_stall,
  output logic [CNT_W-1:0] perf_flush
`endif
);

  localparam int unsigned CW = $clog2(MEM_TIMEOUT + 2);

  typedef enum logic [1:0] {RUN, MEMWAIT, ERR} state_t;

  state_t          state;
  logic [CW-1:0]   wait_cnt;
  logic [4:0]      ex_rd;
  logic            ex_we;
  logic            ex_load;
  logic [4:0]      wb_rd;
  logic            wb_we;
  logic            frozen;
  logic            load_use;
  logic            kill;

  // Forward select for one source operand; an EX match wins over WB.
  function automatic logic [1:0] fwd_sel(input logic [4:0] rs, input logic used,
                                         input logic [4:0] erd, input logic ewe,
                                         input logic [4:0] wrd, input logic wwe);
    if (!used || rs == 5'd0)      return 2'b00;
    else if (ewe && rs == erd)    return 2'b01;
    else if (wwe && rs == wrd)    return 2'b10;
    else                          return 2'b00;
  endfunction

  // Hazard decode: memory freeze dominates, then redirect, then load-use.
  always_comb begin
    stall_if  = 1'b0;
    stall_id  = 1'b0;
    stall_ex  = 1'b0;
    bubble_ex = 1'b0;
    flush_id  = 1'b0;
    frozen    = (state == ERR) ||
                (state == MEMWAIT && !dmem_ready) ||
                (state == RUN && dmem_req && !dmem_ready);
    load_use  = id_valid && ex_load && ex_we && (ex_rd != 5'd0) &&
                ((id_rs1_used && id_rs1 == ex_rd) || (id_rs2_used && id_rs2 == ex_rd));
    if (frozen) begin
      stall_if = 1'b1;
      stall_id = 1'b1;
      stall_ex = 1'b1;
    end else if (ex_redirect) begin
      flush_id  = 1'b1;
      bubble_ex = 1'b1;
    end else if (load_use) begin
      stall_if  = 1'b1;
      stall_id  = 1'b1;
      bubble_ex = 1'b1;
    end
    kill = bubble_ex || !id_valid;
  end

  // Memory-wait FSM with watchdog and sticky error.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= RUN;
      wait_cnt <= '0;
      mem_err  <= 1'b0;
    end else begin
      case (state)
        RUN: begin
          if (dmem_req && !dmem_ready) begin
            state    <= MEMWAIT;
            wait_cnt <= '0;
          end
        end
        MEMWAIT: begin
          if (dmem_ready) begin
            state <= RUN;
          end else if (MEM_TIMEOUT != 0 && wait_cnt == CW'(MEM_TIMEOUT - 1)) begin
            state   <= ERR;
            mem_err <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + CW'(1);
          end
        end
        ERR:     mem_err <= 1'b1;
        default: state <= RUN;
      endcase
    end
  end

  // Destination scoreboard and registered forward selects, moved on advance.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ex_rd   <= 5'd0;
      ex_we   <= 1'b0;
      ex_load <= 1'b0;
      wb_rd   <= 5'd0;
      wb_we   <= 1'b0;
      fwda    <= 2'b00;
      fwdb    <= 2'b00;
    end else if (!stall_ex) begin
      wb_rd   <= ex_rd;
      wb_we   <= ex_we;
      ex_rd   <= kill ? 5'd0 : id_rd;
      ex_we   <= !kill && id_rd_we;
      ex_load <= !kill && id_is_load;
      fwda    <= kill ? 2'b00 : fwd_sel(id_rs1, id_rs1_used, ex_rd, ex_we, wb_rd, wb_we);
      fwdb    <= kill ? 2'b00 : fwd_sel(id_rs2, id_rs2_used, ex_rd, ex_we, wb_rd, wb_we);
    end
  end

`ifdef HAZARD_CTRL_PERF_EN
  // Saturating stall-cycle and flush-pulse counters.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      perf_stall <= '0;
      perf_flush <= '0;
    end else begin
      if (stall_if && perf_stall != '1) perf_stall <= perf_stall + CNT_W'(1);
      if (flush_id && perf_flush != '1) perf_flush <= perf_flush + CNT_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: vector table, corner sequences, random vs reference model.
module tb_hazard_ctrl;
  localparam int unsigned TO = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n, id_valid, id_rs1_used, id_rs2_used, id_rd_we, id_is_load;
  logic ex_redirect, dmem_req, dmem_ready;
  logic [4:0] id_rs1, id_rs2, id_rd;
  logic stall_if, stall_id, stall_ex, bubble_ex, flush_id, mem_err;
  logic [1:0] fwda, fwdb;
`ifdef HAZARD_CTRL_PERF_EN
  logic [31:0] perf_stall, perf_flush;
`endif

  hazard_ctrl #(.MEM_TIMEOUT(TO), .CNT_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used), .id_rd(id_rd),
    .id_rd_we(id_rd_we), .id_is_load(id_is_load), .ex_redirect(ex_redirect),
    .dmem_req(dmem_req), .dmem_ready(dmem_ready), .stall_if(stall_if),
    .stall_id(stall_id), .stall_ex(stall_ex), .bubble_ex(bubble_ex),
    .flush_id(flush_id), .fwda(fwda), .fwdb(fwdb), .mem_err(mem_err)
`ifdef HAZARD_CTRL_PERF_EN
    , .perf_stall(perf_stall), .perf_flush(perf_flush)
`endif
  );

  typedef struct {
    logic rst_n; logic valid;
    logic [4:0] rs1; logic u1; logic [4:0] rs2; logic u2;
    logic [4:0] rd; logic we; logic load;
    logic redir; logic req; logic ready;
  } in_t;

  typedef struct { logic [4:0] rd; logic we; logic load; } slot_t;

  typedef struct {
    logic [4:0] prd; logic pwe; logic pload;
    logic [4:0] rs1; logic u1; logic [4:0] rs2; logic u2; logic redir;
    logic xs; logic xb; logic xf; logic [1:0] xa; logic [1:0] xbb;
  } vec_t;

  int checks = 0;
  int errors = 0;

  // reference model: which instruction sits in EX and in WB, plus memory mode
  int          m_mode;   // 0 running, 1 waiting on memory, 2 error
  int          m_waits;  // consecutive wait cycles seen
  logic        m_err;
  slot_t       m_ex, m_wb;
  logic [1:0]  m_fa, m_fb;
  int unsigned m_ps, m_pf;
  logic        e_si, e_sid, e_sex, e_bub, e_fl;
  in_t         cur;
  vec_t        tbl[8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic in_t mk(input logic valid, input logic [4:0] rs1, input logic u1,
                             input logic [4:0] rs2, input logic u2, input logic [4:0] rd,
                             input logic we, input logic load, input logic redir,
                             input logic req, input logic ready);
    in_t v;
    v.rst_n = 1'b1; v.valid = valid; v.rs1 = rs1; v.u1 = u1; v.rs2 = rs2; v.u2 = u2;
    v.rd = rd; v.we = we; v.load = load; v.redir = redir; v.req = req; v.ready = ready;
    return v;
  endfunction

  function automatic logic [1:0] m_sel(input logic [4:0] rs, input logic used);
    if (!used || rs == 5'd0) return 2'b00;
    if (m_ex.we && m_ex.rd == rs) return 2'b01;
    if (m_wb.we && m_wb.rd == rs) return 2'b10;
    return 2'b00;
  endfunction

  task automatic model_comb(input in_t v);
    logic frozen, lu;
    frozen = (m_mode == 2) || (m_mode == 1 && !v.ready) || (m_mode == 0 && v.req && !v.ready);
    lu = v.valid && m_ex.load && m_ex.we && m_ex.rd != 5'd0 &&
         ((v.u1 && v.rs1 == m_ex.rd) || (v.u2 && v.rs2 == m_ex.rd));
    {e_si, e_sid, e_sex, e_bub, e_fl} = 5'b0;
    if (frozen) {e_si, e_sid, e_sex} = 3'b111;
    else if (v.redir) {e_fl, e_bub} = 2'b11;
    else if (lu) {e_si, e_sid, e_bub} = 3'b111;
  endtask

  task automatic model_update(input in_t v);
    logic [1:0] na, nb;
    logic kill;
    if (!v.rst_n) begin
      m_mode = 0; m_waits = 0; m_err = 1'b0; m_fa = 2'b00; m_fb = 2'b00;
      m_ex = '{5'd0, 1'b0, 1'b0}; m_wb = '{5'd0, 1'b0, 1'b0}; m_ps = 0; m_pf = 0;
      return;
    end
    if (e_si && m_ps != 32'hFFFF_FFFF) m_ps++;
    if (e_fl && m_pf != 32'hFFFF_FFFF) m_pf++;
    if (!e_sex) begin
      kill = e_bub || !v.valid;
      na = kill ? 2'b00 : m_sel(v.rs1, v.u1);
      nb = kill ? 2'b00 : m_sel(v.rs2, v.u2);
      m_wb = m_ex;
      m_ex = kill ? '{5'd0, 1'b0, 1'b0} : '{v.rd, v.we, v.load};
      m_fa = na; m_fb = nb;
    end
    if (m_mode == 0) begin
      if (v.req && !v.ready) begin m_mode = 1; m_waits = 0; end
    end else if (m_mode == 1) begin
      if (v.ready) m_mode = 0;
      else begin
        m_waits++;
        if (TO != 0 && m_waits >= TO) begin m_mode = 2; m_err = 1'b1; end
      end
    end
  endtask

  task automatic apply(input in_t v);
    cur = v;
    rst_n = v.rst_n; id_valid = v.valid; id_rs1 = v.rs1; id_rs1_used = v.u1;
    id_rs2 = v.rs2; id_rs2_used = v.u2; id_rd = v.rd; id_rd_we = v.we;
    id_is_load = v.load; ex_redirect = v.redir; dmem_req = v.req; dmem_ready = v.ready;
  endtask

  task automatic drive_check(input in_t v);
    apply(v);
    #1;
    model_comb(v);
    chk("stall_if", 32'(stall_if), 32'(e_si));
    chk("stall_id", 32'(stall_id), 32'(e_sid));
    chk("stall_ex", 32'(stall_ex), 32'(e_sex));
    chk("bubble_ex", 32'(bubble_ex), 32'(e_bub));
    chk("flush_id", 32'(flush_id), 32'(e_fl));
    chk("fwda", 32'(fwda), 32'(m_fa));
    chk("fwdb", 32'(fwdb), 32'(m_fb));
    chk("mem_err", 32'(mem_err), 32'(m_err));
`ifdef HAZARD_CTRL_PERF_EN
    chk("perf_stall", perf_stall, m_ps);
    chk("perf_flush", perf_flush, m_pf);
`endif
  endtask

  task automatic clock();
    @(posedge clk);
    model_update(cur);
    @(negedge clk);
  endtask

  task automatic do_reset();
    in_t v;
    v = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    v.rst_n = 1'b0;
    drive_check(v);
    clock();
  endtask

  function automatic in_t idle();
    return mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endfunction

  initial begin
    in_t v;
    int n;

    // {prod rd,we,load, rs1,u1, rs2,u2, redirect, stall,bubble,flush, fwda,fwdb}
    tbl[0] = '{5'd5, 1'b1, 1'b0, 5'd5, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b01, 2'b01};
    tbl[1] = '{5'd7, 1'b1, 1'b1, 5'd7, 1'b1, 5'd3, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 2'b00, 2'b00};
    tbl[2] = '{5'd7, 1'b1, 1'b1, 5'd7, 1'b1, 5'd3, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 2'b00, 2'b00};
    tbl[3] = '{5'd0, 1'b1, 1'b0, 5'd0, 1'b1, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00};
    tbl[4] = '{5'd9, 1'b1, 1'b0, 5'd9, 1'b0, 5'd9, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b01};
    tbl[5] = '{5'd9, 1'b0, 1'b0, 5'd9, 1'b1, 5'd9, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00};
    tbl[6] = '{5'd7, 1'b1, 1'b1, 5'd1, 1'b0, 5'd7, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 2'b00, 2'b00};
    tbl[7] = '{5'd0, 1'b1, 1'b1, 5'd0, 1'b1, 5'd2, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00};

    v = idle();
    v.rst_n = 1'b0;
    apply(v);
    @(negedge clk);
    clock();
    drive_check(idle());
    chk("reset_fwda", 32'(fwda), 32'd0);
    chk("reset_stall_ex", 32'(stall_ex), 32'd0);

    // table: producer into EX, then consumer in ID
    for (int i = 0; i < 8; i++) begin
      do_reset();
      drive_check(mk(1, 0, 0, 0, 0, tbl[i].prd, tbl[i].pwe, tbl[i].pload, 0, 0, 0));
      clock();
      drive_check(mk(1, tbl[i].rs1, tbl[i].u1, tbl[i].rs2, tbl[i].u2, 5'd20, 0, 0,
                     tbl[i].redir, 0, 0));
      chk($sformatf("vec%0d_stall_if", i), 32'(stall_if), 32'(tbl[i].xs));
      chk($sformatf("vec%0d_bubble", i), 32'(bubble_ex), 32'(tbl[i].xb));
      chk($sformatf("vec%0d_flush", i), 32'(flush_id), 32'(tbl[i].xf));
      clock();
      chk($sformatf("vec%0d_fwda", i), 32'(fwda), 32'(tbl[i].xa));
      chk($sformatf("vec%0d_fwdb", i), 32'(fwdb), 32'(tbl[i].xbb));
    end

    // WB forward after one gap instruction
    do_reset();
    drive_check(mk(1, 0, 0, 0, 0, 5'd5, 1, 0, 0, 0, 0)); clock();
    drive_check(idle()); clock();
    drive_check(mk(1, 5'd5, 1, 5'd0, 0, 5'd6, 1, 0, 0, 0, 0)); clock();
    chk("wb_fwda", 32'(fwda), 32'd2);

    // EX match beats WB match
    do_reset();
    drive_check(mk(1, 0, 0, 0, 0, 5'd5, 1, 0, 0, 0, 0)); clock();
    drive_check(mk(1, 0, 0, 0, 0, 5'd5, 1, 0, 0, 0, 0)); clock();
    drive_check(mk(1, 5'd5, 1, 5'd5, 1, 5'd6, 1, 0, 0, 0, 0)); clock();
    chk("prio_fwda", 32'(fwda), 32'd1);
    chk("prio_fwdb", 32'(fwdb), 32'd1);

    // load-use: one stall cycle, then WB forward
    do_reset();
    drive_check(mk(1, 0, 0, 0, 0, 5'd7, 1, 1, 0, 0, 0)); clock();
    drive_check(mk(1, 5'd7, 1, 5'd0, 0, 5'd8, 1, 0, 0, 0, 0));
    chk("lu_stall1", 32'(stall_if), 32'd1);
    clock();
    drive_check(mk(1, 5'd7, 1, 5'd0, 0, 5'd8, 1, 0, 0, 0, 0));
    chk("lu_stall2", 32'(stall_if), 32'd0);
    clock();
    chk("lu_fwda", 32'(fwda), 32'd2);

    // memory wait: miss plus three waiting cycles, then ready
    do_reset();
    n = 0;
    drive_check(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0)); n += int'(stall_ex); clock();
    for (int k = 0; k < 3; k++) begin
      drive_check(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0)); n += int'(stall_ex); clock();
    end
    drive_check(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
    chk("wait_drop", 32'(stall_ex), 32'd0);
    n += int'(stall_ex);
    clock();
    chk("wait_len", 32'(n), 32'd4);
`ifdef HAZARD_CTRL_PERF_EN
    chk("perf_wait", perf_stall, 32'd4);
`endif

    // watchdog: four waiting cycles without ready -> error, reset clears
    do_reset();
    drive_check(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0)); clock();
    for (int k = 0; k < 4; k++) begin
      drive_check(mk(1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0));
      if (k == 3) chk("wd_not_yet", 32'(mem_err), 32'd0);
      clock();
    end
    chk("wd_err", 32'(mem_err), 32'd1);
    drive_check(mk(1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1));
    chk("err_no_flush", 32'(flush_id), 32'd0);
    chk("err_stall", 32'(stall_if), 32'd1);
    clock();
    do_reset();
    drive_check(idle());
    chk("err_cleared", 32'(mem_err), 32'd0);
    chk("err_unstall", 32'(stall_ex), 32'd0);

    // random traffic against the model
    for (int c = 0; c < 3000; c++) begin
      v.rst_n = ($urandom_range(63) != 0);
      v.valid = ($urandom_range(3) != 0);
      v.rs1   = 5'($urandom_range(3));
      v.rs2   = 5'($urandom_range(3));
      v.u1    = 1'($urandom);
      v.u2    = 1'($urandom);
      v.rd    = 5'($urandom_range(3));
      v.we    = ($urandom_range(3) != 0);
      v.load  = 1'($urandom);
      v.redir = ($urandom_range(9) == 0);
      v.req   = ($urandom_range(7) == 0);
      v.ready = 1'($urandom);
      drive_check(v);
      clock();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1);
  end
endmodule
